// File: rtl/mm_pkg.sv
// Shared constants, FSM encoding and helpers for the matrix write-back path.
package mm_pkg;

  localparam int LANE_NUM    = 16;
  localparam int LINE_W      = 128;
  localparam int LINE_ADDR_W = 8;
  localparam int BYTE_ADDR_W = 12;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_RUN  = 2'd1,
    WB_DONE = 2'd2
  } wb_state_e;

  // Byte enables for lanes 0..col_len.
  function automatic logic [LANE_NUM-1:0] lane_mask(input logic [CNT_W-1:0] col_len);
    logic [LANE_NUM-1:0] m;
    m = '0;
    for (int i = 0; i < LANE_NUM; i++) m[i] = (CNT_W'(i) <= col_len);
    return m;
  endfunction

endpackage

// File: rtl/mm_result_buffer_if.sv
// Control, MXU result and RAM write signals of the write-back collector.
interface mm_result_buffer_if;
  import mm_pkg::*;

  logic                   lsu_mm_wb_ctrl_vld;
  logic [CNT_W-1:0]       lsu_mm_wb_ctrl_row_len;
  logic [CNT_W-1:0]       lsu_mm_wb_ctrl_col_len;
  logic [BYTE_ADDR_W-1:0] lsu_mm_wb_ctrl_start_addr;
  logic [LANE_NUM-1:0]    mxu_mm_wb_vld;
  logic [LINE_W-1:0]      mxu_mm_wb_data;
  logic                   lsu_mm_wb_ram_write_vld;
  logic [LINE_ADDR_W-1:0] lsu_mm_wb_ram_write_addr;
  logic [LINE_W-1:0]      lsu_mm_wb_ram_write_data;
  logic [LANE_NUM-1:0]    lsu_mm_wb_ram_write_mask;
  logic                   lsu_mm_wb_ram_write_rdy;
  logic                   lsu_mm_wb_busy;
  logic                   lsu_mm_wb_done;
  logic                   lsu_mm_wb_err;

  modport slave (
    input  lsu_mm_wb_ctrl_vld, lsu_mm_wb_ctrl_row_len, lsu_mm_wb_ctrl_col_len,
           lsu_mm_wb_ctrl_start_addr, mxu_mm_wb_vld, mxu_mm_wb_data, lsu_mm_wb_ram_write_rdy,
    output lsu_mm_wb_ram_write_vld, lsu_mm_wb_ram_write_addr, lsu_mm_wb_ram_write_data,
           lsu_mm_wb_ram_write_mask, lsu_mm_wb_busy, lsu_mm_wb_done, lsu_mm_wb_err
  );

  modport master (
    output lsu_mm_wb_ctrl_vld, lsu_mm_wb_ctrl_row_len, lsu_mm_wb_ctrl_col_len,
           lsu_mm_wb_ctrl_start_addr, mxu_mm_wb_vld, mxu_mm_wb_data, lsu_mm_wb_ram_write_rdy,
    input  lsu_mm_wb_ram_write_vld, lsu_mm_wb_ram_write_addr, lsu_mm_wb_ram_write_data,
           lsu_mm_wb_ram_write_mask, lsu_mm_wb_busy, lsu_mm_wb_done, lsu_mm_wb_err
  );

endinterface

// File: rtl/mm_wb_row_entry.sv
// One de-skew row line: 16 byte lanes, each with its own write enable.
module mm_wb_row_entry
  import mm_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic [LANE_NUM-1:0] we,
  input  logic [LINE_W-1:0]   wdata,
  output logic [LINE_W-1:0]   q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      for (int b = 0; b < LANE_NUM; b++)
        if (we[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

endmodule

// File: rtl/mm_result_buffer.sv
// Collects skewed MXU result bytes into row lines and drains them as masked
// RAM line writes starting at the programmed line address.
module mm_result_buffer
  import mm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  mm_result_buffer_if.slave wb
);

  wb_state_e              state;
  logic [CNT_W-1:0]       row_len_q, col_len_q;
  logic [LINE_ADDR_W-1:0] start_line_q;
  logic [CNT_W:0]         cc, rd_ptr;
  logic                   err_q;
  logic [CNT_W:0]         lane_cnt [LANE_NUM];
  logic [LINE_W-1:0]      entry_q  [LANE_NUM];
  logic [LANE_NUM-1:0]    col_mask, cap_en, ovr;
  logic [LINE_W-1:0]      rd_line, wr_data;
  logic                   run, accept, complete, wr_vld, hs, last;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^wb.lsu_mm_wb_ctrl_start_addr[3:0];
  assign run      = (state == WB_RUN);
  assign accept   = wb.lsu_mm_wb_ctrl_vld & ~run;
  assign col_mask = lane_mask(col_len_q);

  // Lane counters are 5 bits so a 17th byte with row_len=15 still reads as overrun.
  for (genvar c = 0; c < LANE_NUM; c++) begin : g_lane
    logic act, room;
    assign act       = run & wb.mxu_mm_wb_vld[c] & col_mask[c];
    assign room      = (lane_cnt[c] <= {1'b0, row_len_q});
    assign cap_en[c] = act & room;
    assign ovr[c]    = act & ~room;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          lane_cnt[c] <= '0;
      else if (accept)     lane_cnt[c] <= '0;
      else if (cap_en[c])  lane_cnt[c] <= lane_cnt[c] + (CNT_W+1)'(1);
    end
  end

  for (genvar k = 0; k < LANE_NUM; k++) begin : g_entry
    logic [LANE_NUM-1:0] we;
    always_comb begin
      we = '0;
      for (int c = 0; c < LANE_NUM; c++)
        we[c] = cap_en[c] & (lane_cnt[c] == (CNT_W+1)'(k));
    end

    mm_wb_row_entry u_entry (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .we    (we),
      .wdata (wb.mxu_mm_wb_data),
      .q     (entry_q[k])
    );
  end

  // The last valid lane trails the skew, so its capture marks the row complete.
  assign complete = cap_en[col_len_q];
  assign wr_vld   = run & (rd_ptr < cc);
  assign hs       = wr_vld & wb.lsu_mm_wb_ram_write_rdy;
  assign last     = hs & (rd_ptr[CNT_W-1:0] == row_len_q);
  assign rd_line  = entry_q[rd_ptr[CNT_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WB_IDLE;
      row_len_q    <= '0;
      col_len_q    <= '0;
      start_line_q <= '0;
      cc           <= '0;
      rd_ptr       <= '0;
      err_q        <= 1'b0;
    end else if (accept) begin
      state        <= WB_RUN;
      row_len_q    <= wb.lsu_mm_wb_ctrl_row_len;
      col_len_q    <= wb.lsu_mm_wb_ctrl_col_len;
      start_line_q <= wb.lsu_mm_wb_ctrl_start_addr[BYTE_ADDR_W-1 -: LINE_ADDR_W];
      cc           <= '0;
      rd_ptr       <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        WB_RUN: begin
          if (complete) cc     <= cc + (CNT_W+1)'(1);
          if (hs)       rd_ptr <= rd_ptr + (CNT_W+1)'(1);
          if (|ovr)     err_q  <= 1'b1;
          if (last)     state  <= WB_DONE;
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_data = '0;
    for (int c = 0; c < LANE_NUM; c++)
      if (wr_vld & col_mask[c]) wr_data[c*8 +: 8] = rd_line[c*8 +: 8];
  end

  assign wb.lsu_mm_wb_ram_write_vld  = wr_vld;
  assign wb.lsu_mm_wb_ram_write_addr = wr_vld ? start_line_q + LINE_ADDR_W'(rd_ptr) : '0;
  assign wb.lsu_mm_wb_ram_write_data = wr_data;
  assign wb.lsu_mm_wb_ram_write_mask = wr_vld ? col_mask : '0;
  assign wb.lsu_mm_wb_busy           = run;
  assign wb.lsu_mm_wb_done           = (state == WB_DONE);
  assign wb.lsu_mm_wb_err            = err_q;

endmodule

// File: tb/tb_mm_result_buffer.sv
// Self-checking bench for mm_result_buffer: job table plus scoreboarded RAM writes.
module tb_mm_result_buffer;
  import mm_pkg::*;

  typedef struct {
    logic [7:0]   addr;
    logic [127:0] data;
    logic [15:0]  mask;
  } wr_t;

  typedef struct {
    logic [3:0]  row_len;
    logic [3:0]  col_len;
    logic [11:0] start;
    int          gap_max;
    int          stall_at;
    logic [7:0]  seed;
    logic [7:0]  exp_addr;
    logic [15:0] exp_mask;
    int          exp_writes;
  } job_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0, fails = 0;
  int   wr_cnt = 0, stall_at = 0, stall_cnt = 0, done_cnt = 0;
  bit   exp_done_next = 0, held_prev = 0;
  wr_t  held;
  wr_t  sb[$];
  job_t jobs[5];

  always #5 clk = ~clk;

  mm_result_buffer_if wb();
  mm_result_buffer dut (.clk(clk), .rst_n(rst_n), .wb(wb));

  function automatic logic [7:0] pat(int k, int c, logic [7:0] seed);
    return 8'(16 * k + c) + seed;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // RAM side: drives rdy (with optional stall window) and scores every handshake.
  always @(negedge clk) begin
    wr_t w;
    wb.lsu_mm_wb_ram_write_rdy = (stall_cnt == 0);
    if (stall_cnt > 0) stall_cnt--;
    #1;
    if (rst_n) begin
      if (exp_done_next) begin
        check("done_after_last_write", 128'(wb.lsu_mm_wb_done), 128'(1));
        check("busy_low_in_done", 128'(wb.lsu_mm_wb_busy), 128'(0));
        exp_done_next = 0;
      end else if (wb.lsu_mm_wb_done) begin
        check("spurious_done", 128'(wb.lsu_mm_wb_done), 128'(0));
      end
      if (wb.lsu_mm_wb_done) done_cnt++;
      if (held_prev) begin
        check("hold_vld", 128'(wb.lsu_mm_wb_ram_write_vld), 128'(1));
        check("hold_addr", 128'(wb.lsu_mm_wb_ram_write_addr), 128'(held.addr));
        check("hold_data", wb.lsu_mm_wb_ram_write_data, held.data);
        check("hold_mask", 128'(wb.lsu_mm_wb_ram_write_mask), 128'(held.mask));
      end
      if (wb.lsu_mm_wb_ram_write_vld && wb.lsu_mm_wb_ram_write_rdy) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL extra_write: addr 0x%0h with no write expected", wb.lsu_mm_wb_ram_write_addr);
        end else begin
          w = sb.pop_front();
          check("wr_addr", 128'(wb.lsu_mm_wb_ram_write_addr), 128'(w.addr));
          check("wr_data", wb.lsu_mm_wb_ram_write_data, w.data);
          check("wr_mask", 128'(wb.lsu_mm_wb_ram_write_mask), 128'(w.mask));
          wr_cnt++;
          if (stall_at != 0 && wr_cnt == stall_at) stall_cnt = 5;
          if (sb.size() == 0) exp_done_next = 1;
        end
        held_prev = 0;
      end else if (wb.lsu_mm_wb_ram_write_vld) begin
        held_prev = 1;
        held.addr = wb.lsu_mm_wb_ram_write_addr;
        held.data = wb.lsu_mm_wb_ram_write_data;
        held.mask = wb.lsu_mm_wb_ram_write_mask;
      end else begin
        held_prev = 0;
      end
    end
  end

  // Lane c may send row k only after lane c-1 has, so the last valid lane trails.
  task automatic drive_mxu(int row_len, int col_len, int gap_max, logic [7:0] seed);
    int sent[16];
    int prev[16];
    int gap[16];
    logic [15:0]  v;
    logic [127:0] d;
    bit active;
    int cyc;
    for (int c = 0; c < 16; c++) begin
      sent[c] = 0;
      gap[c]  = int'($urandom_range(gap_max));
    end
    cyc = 0;
    while (1) begin
      prev   = sent;
      active = 0;
      v      = '0;
      d      = {$urandom(), $urandom(), $urandom(), $urandom()};
      for (int c = 0; c < 16; c++) begin
        if (c > col_len) begin
          v[c] = 1'($urandom_range(1));
        end else if (sent[c] <= row_len) begin
          active = 1;
          if (gap[c] > 0) begin
            gap[c]--;
          end else if (c == 0 || prev[c-1] > sent[c]) begin
            v[c]          = 1'b1;
            d[c*8 +: 8]   = pat(sent[c], c, seed);
            sent[c]++;
            gap[c]        = int'($urandom_range(gap_max));
          end
        end
      end
      if (!active) break;
      if (cyc++ > 500) begin
        checks++;
        fails++;
        $display("FAIL mxu_drive_timeout: lanes still pending after %0d cycles", cyc);
        break;
      end
      wb.mxu_mm_wb_vld  = v;
      wb.mxu_mm_wb_data = d;
      @(negedge clk);
    end
    wb.mxu_mm_wb_vld = '0;
  endtask

  // Entered between a negedge and the following posedge.
  task automatic run_job(job_t j);
    wr_t w;
    int  d0;
    wr_cnt   = 0;
    stall_at = j.stall_at;
    d0       = done_cnt;
    for (int k = 0; k <= int'(j.row_len); k++) begin
      w.addr = j.exp_addr + 8'(k);
      w.mask = j.exp_mask;
      w.data = '0;
      for (int c = 0; c <= int'(j.col_len); c++) w.data[c*8 +: 8] = pat(k, c, j.seed);
      sb.push_back(w);
    end
    wb.lsu_mm_wb_ctrl_vld        = 1'b1;
    wb.lsu_mm_wb_ctrl_row_len    = j.row_len;
    wb.lsu_mm_wb_ctrl_col_len    = j.col_len;
    wb.lsu_mm_wb_ctrl_start_addr = j.start;
    @(negedge clk);
    wb.lsu_mm_wb_ctrl_vld = 1'b0;
    #2;
    check("busy_after_accept", 128'(wb.lsu_mm_wb_busy), 128'(1));
    check("err_cleared_on_accept", 128'(wb.lsu_mm_wb_err), 128'(0));
    drive_mxu(int'(j.row_len), int'(j.col_len), j.gap_max, j.seed);
    #2;
    for (int t = 0; t < 300 && done_cnt == d0; t++) begin
      @(negedge clk);
      #2;
    end
    check("done_seen", 128'(done_cnt - d0), 128'(1));
    check("write_count", 128'(wr_cnt), 128'(j.exp_writes));
    check("scoreboard_empty", 128'(sb.size()), 128'(0));
    check("err_at_end", 128'(wb.lsu_mm_wb_err), 128'(0));
  endtask

  initial begin
    int d0;
    wr_t w;
    //           row    col    start    gap stall seed   addr   mask       n
    jobs[0] = '{4'd15, 4'd15, 12'h120, 0, 0, 8'h00, 8'h12, 16'hFFFF, 16};
    jobs[1] = '{4'd2,  4'd3,  12'h340, 0, 0, 8'h33, 8'h34, 16'h000F, 3};
    jobs[2] = '{4'd15, 4'd15, 12'h800, 0, 6, 8'h5C, 8'h80, 16'hFFFF, 16};
    jobs[3] = '{4'd3,  4'd7,  12'hFE0, 3, 0, 8'h91, 8'hFE, 16'h00FF, 4};
    jobs[4] = '{4'd5,  4'd10, 12'h0A7, 2, 2, 8'h44, 8'h0A, 16'h07FF, 6};

    wb.lsu_mm_wb_ctrl_vld        = 1'b0;
    wb.lsu_mm_wb_ctrl_row_len    = '0;
    wb.lsu_mm_wb_ctrl_col_len    = '0;
    wb.lsu_mm_wb_ctrl_start_addr = '0;
    wb.mxu_mm_wb_vld             = '0;
    wb.mxu_mm_wb_data            = '0;

    repeat (2) @(negedge clk);
    #2;
    check("rst_vld", 128'(wb.lsu_mm_wb_ram_write_vld), 128'(0));
    check("rst_addr", 128'(wb.lsu_mm_wb_ram_write_addr), 128'(0));
    check("rst_data", wb.lsu_mm_wb_ram_write_data, 128'(0));
    check("rst_mask", 128'(wb.lsu_mm_wb_ram_write_mask), 128'(0));
    check("rst_busy", 128'(wb.lsu_mm_wb_busy), 128'(0));
    check("rst_done", 128'(wb.lsu_mm_wb_done), 128'(0));
    check("rst_err", 128'(wb.lsu_mm_wb_err), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    #2;

    for (int i = 0; i < 5; i++) begin
      run_job(jobs[i]);
      repeat (2) @(negedge clk);
      #2;
    end

    // Overrun on lane 0 plus a ctrl_vld while running that must be ignored.
    w.addr = 8'h05; w.data = 128'h5A; w.mask = 16'h0001;
    sb.push_back(w);
    wr_cnt = 0; stall_at = 0; d0 = done_cnt;
    wb.lsu_mm_wb_ctrl_vld        = 1'b1;
    wb.lsu_mm_wb_ctrl_row_len    = 4'd0;
    wb.lsu_mm_wb_ctrl_col_len    = 4'd0;
    wb.lsu_mm_wb_ctrl_start_addr = 12'h050;
    @(negedge clk);
    wb.lsu_mm_wb_ctrl_row_len    = 4'd5;
    wb.lsu_mm_wb_ctrl_col_len    = 4'd15;
    wb.lsu_mm_wb_ctrl_start_addr = 12'hAB0;
    wb.mxu_mm_wb_vld             = 16'h0009;
    wb.mxu_mm_wb_data            = {{15{8'hC3}}, 8'h5A};
    @(negedge clk);
    wb.lsu_mm_wb_ctrl_vld = 1'b0;
    wb.mxu_mm_wb_vld      = 16'h0001;
    wb.mxu_mm_wb_data     = {{15{8'h3C}}, 8'h77};
    @(negedge clk);
    wb.mxu_mm_wb_vld = '0;
    #2;
    check("ovr_done_seen", 128'(done_cnt - d0), 128'(1));
    check("ovr_err_set", 128'(wb.lsu_mm_wb_err), 128'(1));
    check("ovr_write_count", 128'(wr_cnt), 128'(1));
    // Still in the DONE cycle: this job must be accepted and clear err.
    run_job(jobs[1]);
    repeat (2) @(negedge clk);
    #2;

    // Reset in the middle of a stalled drain.
    wr_cnt = 0; stall_at = 1; d0 = done_cnt;
    for (int k = 0; k < 4; k++) begin
      w.addr = 8'h20 + 8'(k); w.data = 128'(pat(k, 0, 8'hA0)); w.mask = 16'h0001;
      sb.push_back(w);
    end
    wb.lsu_mm_wb_ctrl_vld        = 1'b1;
    wb.lsu_mm_wb_ctrl_row_len    = 4'd3;
    wb.lsu_mm_wb_ctrl_col_len    = 4'd0;
    wb.lsu_mm_wb_ctrl_start_addr = 12'h200;
    @(negedge clk);
    wb.lsu_mm_wb_ctrl_vld = 1'b0;
    drive_mxu(3, 0, 0, 8'hA0);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_vld", 128'(wb.lsu_mm_wb_ram_write_vld), 128'(0));
    check("midrst_addr", 128'(wb.lsu_mm_wb_ram_write_addr), 128'(0));
    check("midrst_data", wb.lsu_mm_wb_ram_write_data, 128'(0));
    check("midrst_mask", 128'(wb.lsu_mm_wb_ram_write_mask), 128'(0));
    check("midrst_busy", 128'(wb.lsu_mm_wb_busy), 128'(0));
    check("midrst_done", 128'(wb.lsu_mm_wb_done), 128'(0));
    sb.delete();
    held_prev = 0; exp_done_next = 0; stall_cnt = 0; stall_at = 0;
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    check("midrst_writes_before_reset", 128'(wr_cnt), 128'(1));
    check("midrst_no_done", 128'(done_cnt - d0), 128'(0));
    run_job(jobs[3]);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
